// File: rtl/uart_echo_responder.sv
`default_nettype none
// ============================================================================
// Module      : uart_echo_responder
// Description : Sits between uart_rx and uart_tx. Each good received byte is
//               XORed with ECHO_XOR, queued in a FIFO, and offered back to the
//               transmitter. Saturating statistics separate accepted, errored
//               and dropped bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_echo_responder #(
    parameter int                   DATA_BITS  = 8,
    parameter int                   FIFO_DEPTH = 16,
    parameter logic [DATA_BITS-1:0] ECHO_XOR   = '0,
    parameter int                   GAP_CYCLES = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic [DATA_BITS-1:0]            rx_data,
    input  logic                            rx_valid,
    input  logic                            rx_error,
    output logic [DATA_BITS-1:0]            tx_data,
    output logic                            tx_valid,
    input  logic                            tx_ready,
    input  logic                            clear_stats,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow,
    output logic [15:0]                     byte_count,
    output logic [15:0]                     err_count,
    output logic [15:0]                     drop_count
);

    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int LVL_W    = PTR_W + 1;
    localparam int GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(FIFO_DEPTH);
    localparam logic [GAP_W-1:0] GAP_END    = GAP_W'(GAP_LAST);
    localparam logic [15:0]      CNT_MAX    = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OFFER = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t                 state;
    logic [GAP_W-1:0]       gap_cnt;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;

    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic good_byte;
    logic err_event;
    logic push;
    logic drop;

    // Full/empty come from the occupancy count, so pointer equality is never ambiguous.
    assign fifo_empty = (fifo_level == '0);
    assign fifo_full  = (fifo_level == FULL_LEVEL);

    // The egress FSM takes the head whenever it is idle and something is queued.
    assign pop        = (state == S_IDLE) && !fifo_empty;

    // A full FIFO still has room for a byte if the head leaves on the same edge.
    assign good_byte  = rx_valid && enable && !rx_error;
    assign err_event  = rx_valid && enable && rx_error;
    assign push       = good_byte && (!fifo_full || pop);
    assign drop       = good_byte && fifo_full && !pop;

    // Storage array: written on push only, no reset needed on the data.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_data ^ ECHO_XOR;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop together keep the level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Egress FSM: load the head, hold the offer until accepted, then stay quiet
    // for GAP_CYCLES so uart_tx has time to drop tx_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        tx_data  <= mem[rd_ptr];
                        tx_valid <= 1'b1;
                        state    <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        gap_cnt  <= '0;
                        if (GAP_CYCLES == 0) begin
                            state <= S_IDLE;
                        end else begin
                            state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_END) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

    // Saturating statistics; a clear on the same edge as an event wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_count <= '0;
            err_count  <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (clear_stats) begin
            byte_count <= '0;
            err_count  <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push && (byte_count != CNT_MAX)) begin
                byte_count <= byte_count + 16'd1;
            end
            if (err_event && (err_count != CNT_MAX)) begin
                err_count <= err_count + 16'd1;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != CNT_MAX) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_echo_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_echo_responder
// Description : Self-checking bench for uart_echo_responder. A queue-based
//               model predicts every output each cycle; directed scenarios
//               pin the model with hand-computed values, then random traffic
//               runs against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_echo_responder;

    localparam int         DEPTH = 16;
    localparam int         GAP   = 2;
    localparam logic [7:0] XMASK = 8'hFF;

    logic       clk         = 1'b0;
    logic       rst         = 1'b1;
    logic       enable      = 1'b0;
    logic [7:0] rx_data     = 8'h00;
    logic       rx_valid    = 1'b0;
    logic       rx_error    = 1'b0;
    logic       tx_ready    = 1'b0;
    logic       clear_stats = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [4:0] fifo_level;
    logic       overflow;
    logic [15:0] byte_count;
    logic [15:0] err_count;
    logic [15:0] drop_count;

    uart_echo_responder #(
        .DATA_BITS  (8),
        .FIFO_DEPTH (DEPTH),
        .ECHO_XOR   (XMASK),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_error    (rx_error),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .clear_stats (clear_stats),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .byte_count  (byte_count),
        .err_count   (err_count),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Queue holds waiting bytes; one byte may sit "on offer"; after each
    // accepted offer the link stays quiet until ready_at.
    logic [7:0] mq[$];
    bit         m_valid   = 1'b0;
    logic [7:0] m_data    = 8'h00;
    longint     cyc       = 0;
    longint     ready_at  = 0;
    int         m_byte    = 0;
    int         m_err     = 0;
    int         m_drop    = 0;
    bit         m_ovf     = 1'b0;

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit take, accepted, good, do_push;
        if (rst) begin
            mq.delete();
            m_valid  = 1'b0;
            m_data   = 8'h00;
            cyc      = 0;
            ready_at = 0;
            m_byte   = 0;
            m_err    = 0;
            m_drop   = 0;
            m_ovf    = 1'b0;
        end else begin
            take     = !m_valid && (cyc >= ready_at) && (mq.size() > 0);
            accepted = m_valid && tx_ready;
            good     = rx_valid && enable && !rx_error;
            do_push  = 1'b0;
            if (rx_valid && enable && rx_error) m_err = sat(m_err);
            if (good) begin
                if (mq.size() < DEPTH || take) begin
                    do_push = 1'b1;
                    m_byte  = sat(m_byte);
                end else begin
                    m_drop = sat(m_drop);
                    m_ovf  = 1'b1;
                end
            end
            if (accepted) begin
                m_valid  = 1'b0;
                ready_at = cyc + GAP + 1;
            end
            if (take) begin
                m_data  = mq.pop_front();
                m_valid = 1'b1;
            end
            if (do_push) mq.push_back(rx_data ^ XMASK);
            if (clear_stats) begin
                m_byte = 0;
                m_err  = 0;
                m_drop = 0;
                m_ovf  = 1'b0;
            end
            cyc++;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m_tx_valid", {31'd0, tx_valid}, {31'd0, m_valid});
        if (m_valid) chk("m_tx_data", {24'd0, tx_data}, {24'd0, m_data});
        chk("m_level", {27'd0, fifo_level}, mq.size());
        chk("m_overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("m_byte_count", {16'd0, byte_count}, m_byte);
        chk("m_err_count", {16'd0, err_count}, m_err);
        chk("m_drop_count", {16'd0, drop_count}, m_drop);
    end

    // Records every byte the transmitter will accept on the coming edge.
    logic [7:0] got[$];
    bit         rec = 1'b0;
    always @(negedge clk) begin
        if (rec && tx_valid && tx_ready) got.push_back(tx_data);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] d, input bit err, input bit en);
        rx_data  = d;
        rx_error = err;
        enable   = en;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_error = 1'b0;
    endtask

    task automatic clear();
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx_valid", {31'd0, tx_valid}, 0);
        chk("rst_tx_data", {24'd0, tx_data}, 0);
        chk("rst_level", {27'd0, fifo_level}, 0);
        chk("rst_counts", {overflow, byte_count | err_count | drop_count}, 0);
        #2 rst = 1'b0;
        tick();

        // Latency and XOR: 0x3C echoed as 0xC3, offer visible two edges after strobe
        tx_ready = 1'b1;
        strobe(8'h3C, 1'b0, 1'b1);
        chk("lat_not_yet", {31'd0, tx_valid}, 0);
        tick();
        chk("lat_valid", {31'd0, tx_valid}, 1);
        chk("lat_data", {24'd0, tx_data}, 32'hC3);
        tick();
        chk("lat_done", {31'd0, tx_valid}, 0);
        chk("lat_byte_count", {16'd0, byte_count}, 1);
        repeat (5) tick();

        // Overflow: one byte parked on offer, then 18 more into a 16-entry FIFO
        clear();
        tx_ready = 1'b0;
        strobe(8'h99, 1'b0, 1'b1);
        repeat (2) tick();
        for (int i = 0; i < 18; i++) strobe(8'(i), 1'b0, 1'b1);
        tick();
        chk("ovf_level", {27'd0, fifo_level}, 16);
        chk("ovf_drop", {16'd0, drop_count}, 2);
        chk("ovf_flag", {31'd0, overflow}, 1);
        chk("ovf_bytes", {16'd0, byte_count}, 17);

        // Full FIFO with a pop on the same edge as a good push
        got.delete();
        rec      = 1'b1;
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        repeat (2) tick();
        strobe(8'hAB, 1'b0, 1'b1);
        chk("fp_level", {27'd0, fifo_level}, 16);
        chk("fp_drop", {16'd0, drop_count}, 2);
        chk("fp_bytes", {16'd0, byte_count}, 18);

        // Drain and confirm strict ordering
        tx_ready = 1'b1;
        repeat (120) tick();
        rec = 1'b0;
        chk("drain_level", {27'd0, fifo_level}, 0);
        chk("drain_count", got.size(), 18);
        if (got.size() == 18) begin
            chk("drain_first", {24'd0, got[0]}, 32'h66);
            for (int i = 0; i < 16; i++) chk("drain_order", {24'd0, got[i+1]}, {24'd0, ~8'(i)});
            chk("drain_last", {24'd0, got[17]}, 32'h54);
        end

        // Errored and disabled strobes produce nothing but err_count
        clear();
        for (int i = 0; i < 3; i++) strobe(8'($urandom), 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) strobe(8'($urandom), 1'b0, 1'b0);
        enable = 1'b1;
        repeat (10) tick();
        chk("err_err_count", {16'd0, err_count}, 3);
        chk("err_byte_count", {16'd0, byte_count}, 0);
        chk("err_level", {27'd0, fifo_level}, 0);
        chk("err_tx_valid", {31'd0, tx_valid}, 0);

        // Reset in the middle of an offer
        tx_ready = 1'b0;
        strobe(8'h11, 1'b0, 1'b1);
        strobe(8'h22, 1'b0, 1'b1);
        tick();
        chk("mid_offer", {31'd0, tx_valid}, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_tx_valid", {31'd0, tx_valid}, 0);
        chk("arst_level", {27'd0, fifo_level}, 0);
        @(posedge clk);
        #3 rst = 1'b0;
        tick();
        tx_ready = 1'b1;
        strobe(8'h5A, 1'b0, 1'b1);
        tick();
        chk("post_rst_valid", {31'd0, tx_valid}, 1);
        chk("post_rst_data", {24'd0, tx_data}, 32'hA5);
        repeat (5) tick();

        // clear_stats on the same edge as a drop: clear wins
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) strobe(8'(i + 32), 1'b0, 1'b1);
        chk("clr_full", {27'd0, fifo_level}, 16);
        strobe(8'h77, 1'b0, 1'b1);
        chk("clr_pre_drop", {16'd0, drop_count}, 1);
        clear_stats = 1'b1;
        strobe(8'h78, 1'b0, 1'b1);
        clear_stats = 1'b0;
        chk("clr_drop", {16'd0, drop_count}, 0);
        chk("clr_ovf", {31'd0, overflow}, 0);
        chk("clr_level", {27'd0, fifo_level}, 16);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            enable      = ($urandom_range(0, 9) != 0);
            rx_valid    = ($urandom_range(0, 2) == 0);
            rx_error    = ($urandom_range(0, 7) == 0);
            rx_data     = 8'($urandom);
            tx_ready    = ($urandom_range(0, 3) != 0);
            clear_stats = ($urandom_range(0, 199) == 0);
            tick();
        end
        rx_valid    = 1'b0;
        rx_error    = 1'b0;
        clear_stats = 1'b0;
        tx_ready    = 1'b1;
        repeat (100) tick();
        chk("final_level", {27'd0, fifo_level}, 0);
        chk("final_tx_valid", {31'd0, tx_valid}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
